// File: rtl/datapath_pkg.sv
// Shared widths, instruction field positions and constants for the decode/register-read stage.
package datapath_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int IMM_W    = 16;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = 16;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS1_MSB    = 25;
  localparam int RS1_LSB    = 21;
  localparam int RS2_MSB    = 20;
  localparam int RS2_LSB    = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/register_file.sv
// Architectural register file: flop storage, two combinational read ports, commit counter.
// Optional write-through forwarding to the read ports when WB_BYPASS_EN is defined.
module register_file
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [CNT_W-1:0]  write_count_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en;

  // Gating with reset keeps a forwarded value off the operands while the file is held clear.
  assign wr_en   = we_i && (wb_addr_i != REG_ZERO) && !reset;
  assign count_d = wr_en ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    rdata_a_o = (rs1_addr_i == REG_ZERO) ? '0 : regs_q[rs1_addr_i];
    rdata_b_o = (rs2_addr_i == REG_ZERO) ? '0 : regs_q[rs2_addr_i];
`ifdef WB_BYPASS_EN
    if (wr_en && (wb_addr_i == rs1_addr_i)) rdata_a_o = wb_data_i;
    if (wr_en && (wb_addr_i == rs2_addr_i)) rdata_b_o = wb_data_i;
`endif
  end

  assign write_count_o = count_q;

endmodule

// File: rtl/operand_fetch.sv
// Decode/register-read stage: field split, immediate sign extension, register file read.
// Define WB_BYPASS_EN to forward the write-back result to matching operands in the same cycle.
module operand_fetch
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] extended_constant,
  output logic [CNT_W-1:0]  write_count
);

  logic [ADDR_W-1:0] rs1_addr, rs2_addr;
  logic [IMM_W-1:0]  imm;

  assign opcode   = instruction[OPCODE_MSB:OPCODE_LSB];
  assign rs1_addr = instruction[RS1_MSB:RS1_LSB];
  assign rs2_addr = instruction[RS2_MSB:RS2_LSB];
  assign rd_addr  = instruction[RD_MSB:RD_LSB];
  assign imm      = instruction[IMM_MSB:IMM_LSB];

  assign extended_constant = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  register_file u_register_file (
    .clk           (clk),
    .reset         (reset),
    .we_i          (RegWrite),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .rs1_addr_i    (rs1_addr),
    .rs2_addr_i    (rs2_addr),
    .rdata_a_o     (operand_a),
    .rdata_b_o     (operand_b),
    .write_count_o (write_count)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: stimulus pushes model expectations, a monitor compares at negedge.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        RegWrite = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic [5:0]  opcode;
  logic [4:0]  rd_addr;
  logic [31:0] operand_a, operand_b, extended_constant;
  logic [15:0] write_count;

  operand_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .instruction       (instruction),
    .RegWrite          (RegWrite),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .opcode            (opcode),
    .rd_addr           (rd_addr),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .extended_constant (extended_constant),
    .write_count       (write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ext;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mregs [32];
  int unsigned mcount = 0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [15:0] imm);
    return {op, s1, s2, imm};
  endfunction

  // Drive one cycle's inputs; reset (if requested) asserts between edges, after the inputs.
  task automatic cycle(input logic [31:0] instr, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic rst);
    exp_t e;
    int   v;
    @(posedge clk);
    #1;
    instruction = instr;
    RegWrite    = we;
    wb_addr     = wa;
    wb_data     = wd;
    #1 reset = rst;
    if (rst) begin
      foreach (mregs[i]) mregs[i] = '0;
      mcount = 0;
    end
    e.op = instr[31:26];
    e.rd = instr[15:11];
    v = int'(instr[15:0]);
    if (v >= 32768) v = v - 65536;
    e.ext = 32'(v);
    e.a = mregs[instr[25:21]];
    e.b = mregs[instr[20:16]];
`ifdef WB_BYPASS_EN
    if (!rst && we && wa != 0) begin
      if (wa == instr[25:21]) e.a = wd;
      if (wa == instr[20:16]) e.b = wd;
    end
`endif
    e.cnt = 16'(mcount % 65536);
    exp_q.push_back(e);
    if (!rst && we && wa != 0) begin
      mregs[wa] = wd;
      mcount++;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s vector=%0d actual=%h required=%h", n, vectors, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("opcode", 32'(opcode), 32'(e.op));
        chk("rd_addr", 32'(rd_addr), 32'(e.rd));
        chk("operand_a", operand_a, e.a);
        chk("operand_b", operand_b, e.b);
        chk("extended_constant", extended_constant, e.ext);
        chk("write_count", 32'(write_count), 32'(e.cnt));
      end
    end
  end

  logic [31:0] r_instr;
  logic [4:0]  r_wa;

  initial begin : stimulus
    foreach (mregs[i]) mregs[i] = '0;
    cycle(mk(6'd0, 5'd3, 5'd7, 16'h0), 1'b0, 5'd0, 32'h0, 1'b1);
    // reset released mid-cycle; this write lands on the next edge
    cycle(mk(6'd1, 5'd3, 5'd7, 16'h1234), 1'b1, 5'd3, 32'h33, 1'b0);
    cycle(mk(6'd1, 5'd3, 5'd7, 16'h1234), 1'b1, 5'd7, 32'h77, 1'b0);
    cycle(mk(6'd2, 5'd3, 5'd7, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
    cycle(mk(6'd2, 5'd3, 5'd7, 16'h0), 1'b0, 5'd0, 32'h0, 1'b1);
    cycle(mk(6'd0, 5'd0, 5'd0, 16'h0), 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    cycle(mk(6'd0, 5'd5, 5'd0, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
    cycle(mk(6'd0, 5'd5, 5'd0, 16'h0), 1'b1, 5'd0, 32'h12345678, 1'b0);
    cycle(mk(6'd0, 5'd0, 5'd5, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);
    cycle(mk(6'd3, 5'd0, 5'd0, 16'h8000), 1'b0, 5'd0, 32'h0, 1'b0);
    cycle(mk(6'd3, 5'd0, 5'd0, 16'h7FFF), 1'b0, 5'd0, 32'h0, 1'b0);
    cycle(mk(6'd0, 5'd0, 5'd0, 16'h0), 1'b1, 5'd9, 32'h11, 1'b0);
    cycle(mk(6'd0, 5'd9, 5'd9, 16'h0), 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0);
    cycle(mk(6'd0, 5'd9, 5'd9, 16'h0), 1'b0, 5'd0, 32'h0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r_instr = $urandom;
      case ($urandom_range(0, 3))
        0:       r_wa = r_instr[25:21];
        1:       r_wa = r_instr[20:16];
        2:       r_wa = 5'd0;
        default: r_wa = 5'($urandom);
      endcase
      cycle(r_instr, 1'($urandom_range(0, 1)), r_wa, $urandom, $urandom_range(0, 199) == 0);
    end

    // counter wrap: 65536 committed writes from reset
    cycle($urandom, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int i = 0; i < 65536; i++)
      cycle($urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
    cycle($urandom, 1'b0, 5'd0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
